// File: rtl/decode_pkg.sv
// Shared MIPS decode definitions: opcode/funct constants, micro-op record and
// the destination-register rule used by every decode lane.
package decode_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;

   localparam logic [5:0] FN_JALR   = 6'h09;
   localparam logic [4:0] RI_BLTZAL = 5'h10;
   localparam logic [4:0] RI_BGEZAL = 5'h11;
   localparam logic [4:0] REG_RA    = 5'd31;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [25:0] target;
      logic [31:0] imm32;
      logic        is_r;
      logic        is_i;
      logic        is_j;
      logic        link;
      logic [4:0]  dest;
   } uop_t;

   localparam int UOP_W = $bits(uop_t);

   // ALU-immediate (0x08..0x0F, incl. lui) and loads (0x20..0x25) write rt.
   function automatic logic [4:0] calc_dest(input logic [5:0] op,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
      logic [4:0] d;
      d = '0;
      if (op == OP_JAL)
         d = REG_RA;
      else if (op == OP_REGIMM && (rt == RI_BLTZAL || rt == RI_BGEZAL))
         d = REG_RA;
      else if (op == OP_RTYPE)
         d = rd;
      else if (op[5:3] == 3'b001)
         d = rt;
      else if (op[5:3] == 3'b100 && op[2:0] <= 3'd5)
         d = rt;
      return d;
   endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational decoder for a single MIPS instruction into a uop_t record.
module decode_lane
   import decode_pkg::*;
(
   input  logic [31:0]      instr_i,
   input  logic             zext_logical_i,
   output logic [UOP_W-1:0] uop_o
);

   uop_t       u;
   logic [5:0] op;
   logic       zext;

   assign op   = instr_i[31:26];
   assign zext = zext_logical_i && (op == OP_ANDI || op == OP_ORI || op == OP_XORI);

   always_comb begin
      u        = '0;
      u.op     = op;
      u.rs     = instr_i[25:21];
      u.rt     = instr_i[20:16];
      u.rd     = instr_i[15:11];
      u.shamt  = instr_i[10:6];
      u.funct  = instr_i[5:0];
      u.target = instr_i[25:0];
      u.imm32  = zext ? {16'b0, instr_i[15:0]} : {{16{instr_i[15]}}, instr_i[15:0]};
      u.is_r   = (op == OP_RTYPE);
      u.is_j   = (op == OP_J) || (op == OP_JAL);
      u.is_i   = (op != OP_RTYPE) && !u.is_j;
      // funct 0x03 is sra, so only jalr links among R-types
      u.link   = (op == OP_JAL)
               || (op == OP_REGIMM && (u.rt == RI_BLTZAL || u.rt == RI_BGEZAL))
               || (op == OP_RTYPE && u.funct == FN_JALR);
      u.dest   = calc_dest(op, u.rt, u.rd);
   end

   assign uop_o = u;

endmodule

// File: rtl/decode_pipe.sv
// MIPS decode stage: LANES-wide decode in front of a DEPTH-entry bundle FIFO
// with valid/ready on both sides and a flush that wins over everything.
module decode_pipe
   import decode_pkg::*;
#(
   parameter int LANES        = 1,
   parameter int DEPTH        = 2,
   parameter bit ZEXT_LOGICAL = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [LANES-1:0]         in_mask_i,
   input  logic [31:0]              in_pc_i,
   input  logic [32*LANES-1:0]      in_instr_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [LANES-1:0]         out_mask_o,
   output logic [31:0]              out_pc_o,
   output logic [UOP_W*LANES-1:0]   out_uop_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [LANES-1:0][UOP_W-1:0] lane_uop, wr_uop;

   logic [DEPTH-1:0][LANES-1:0][UOP_W-1:0] uop_q;
   logic [DEPTH-1:0][LANES-1:0]            mask_q;
   logic [DEPTH-1:0][31:0]                 pc_q;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      decode_lane u_lane (
         .instr_i        (in_instr_i[32*g +: 32]),
         .zext_logical_i (ZEXT_LOGICAL),
         .uop_o          (lane_uop[g])
      );
      assign wr_uop[g] = in_mask_i[g] ? lane_uop[g] : '0;
   end

   assign in_ready_o  = !flush_i && (count_q < DEPTH_C);
   assign out_valid_o = (count_q != '0);
   // An all-masked bundle completes the handshake but occupies no slot.
   assign push        = in_valid_i && in_ready_o && (|in_mask_i);
   assign pop         = out_valid_o && out_ready_i && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uop_q  <= '0;
         mask_q <= '0;
         pc_q   <= '0;
      end else if (push) begin
         uop_q[wr_ptr_q]  <= wr_uop;
         mask_q[wr_ptr_q] <= in_mask_i;
         pc_q[wr_ptr_q]   <= in_pc_i;
      end
   end

   assign out_mask_o = mask_q[rd_ptr_q];
   assign out_pc_o   = pc_q[rd_ptr_q];
   assign out_uop_o  = uop_q[rd_ptr_q];
   assign count_o    = count_q;

endmodule
